muldiv_seq: RTL and testbench

Multi-cycle sequencer that drives a dedicated 16-bit ALU instance to perform unsigned 16x16->32 multiply (shift-add) and unsigned 32/16 divide (restoring). It uses only the ALU's ADD (IR function 1100) and SUB (IR function 1101) operations, plus the ALU's D and C results. It sits beside the ALU in the execute stage and is launched by a START/DONE handshake from the instruction sequencer.

---
 rtl/muldiv_seq.sv | 150 +++++++++++++++
 tb/tb_muldiv_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned 16x16 multiply (shift-add) and 32/16 divide (restoring)
// that sequences an external 16-bit ALU using only its ADD and SUB functions.
module muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             OP,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    input  logic [WIDTH-1:0] OPC,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF,
    output logic [WIDTH-1:0] RES_HI,
    output logic [WIDTH-1:0] RES_LO,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic             ALU_CIN,
    output logic             ALU_ADD,
    output logic             ALU_BONLY,
    output logic             ALU_IRFC,
    output logic [WIDTH-1:0] ALU_IR,
    input  logic [WIDTH-1:0] ALU_D,
    input  logic             ALU_C
);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} state_t;

    localparam logic [WIDTH-1:0] IR_ADD = 16'h000C;
    localparam logic [WIDTH-1:0] IR_SUB = 16'h000D;

    state_t           state, state_nxt;
    logic             op;
    logic [3:0]       cnt;
    // hi/lo hold the partial product for multiply and R/Q for divide;
    // m holds the multiplicand or the divisor.
    logic [WIDTH-1:0] hi, lo, m;
    logic [WIDTH-1:0] hi_nxt, lo_nxt, div_s;

    assign ALU_CIN   = 1'b0;
    assign ALU_ADD   = 1'b0;
    assign ALU_BONLY = 1'b0;
    assign BUSY      = (state == CHECK) || (state == RUN);
    assign DONE      = (state == FIN);

    always_comb begin
        state_nxt = state;
        ALU_A     = '0;
        ALU_B     = '0;
        ALU_IRFC  = 1'b0;
        ALU_IR    = '0;
        hi_nxt    = hi;
        lo_nxt    = lo;
        div_s     = {hi[WIDTH-2:0], lo[WIDTH-1]};
        case (state)
            IDLE: begin
                if (START)
                    state_nxt = OP ? CHECK : RUN;
            end
            CHECK: begin
                ALU_A     = hi;
                ALU_B     = m;
                ALU_IRFC  = 1'b1;
                ALU_IR    = IR_SUB;
                state_nxt = ALU_C ? RUN : FIN;
            end
            RUN: begin
                ALU_IRFC = 1'b1;
                if (!op) begin
                    ALU_A  = hi;
                    ALU_B  = lo[0] ? m : '0;
                    ALU_IR = IR_ADD;
                    hi_nxt = {ALU_C, ALU_D[WIDTH-1:1]};
                    lo_nxt = {ALU_D[0], lo[WIDTH-1:1]};
                end else begin
                    ALU_A  = div_s;
                    ALU_B  = m;
                    ALU_IR = IR_SUB;
                    // A set R[15] means the shifted remainder exceeds 16 bits,
                    // so it is certainly >= divisor regardless of the borrow.
                    if (hi[WIDTH-1] || !ALU_C) begin
                        hi_nxt = ALU_D;
                        lo_nxt = {lo[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_nxt = div_s;
                        lo_nxt = {lo[WIDTH-2:0], 1'b0};
                    end
                end
                if (cnt == 4'hF)
                    state_nxt = FIN;
            end
            FIN: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            op     <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            m      <= '0;
            OVF    <= 1'b0;
            RES_HI <= '0;
            RES_LO <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (START) begin
                        OVF <= 1'b0;
                        op  <= OP;
                        cnt <= '0;
                        lo  <= OPB;
                        if (OP) begin
                            hi <= OPA;
                            m  <= OPC;
                        end else begin
                            hi <= '0;
                            m  <= OPA;
                        end
                    end
                end
                CHECK: begin
                    if (!ALU_C) begin
                        OVF    <= 1'b1;
                        RES_HI <= '1;
                        RES_LO <= '1;
                    end
                end
                RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 4'd1;
                    // Results are published on the edge into FIN so they are
                    // already valid while DONE is high.
                    if (cnt == 4'hF) begin
                        RES_HI <= hi_nxt;
                        RES_LO <= lo_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: behavioural ALU, arithmetic reference
// model, directed and randomized multiply/divide operations.
module tb_muldiv_seq;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    logic        OP;
    logic [15:0] OPA, OPB, OPC;
    logic        BUSY, DONE, OVF;
    logic [15:0] RES_HI, RES_LO;
    logic [15:0] ALU_A, ALU_B, ALU_IR, ALU_D;
    logic        ALU_CIN, ALU_ADD, ALU_BONLY, ALU_IRFC, ALU_C;

    int compared   = 0;
    int mismatched = 0;
    logic [15:0] prev_hi = 16'h0;
    logic [15:0] prev_lo = 16'h0;

    always #5 CLK = ~CLK;

    muldiv_seq #(.WIDTH(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .OP(OP),
        .OPA(OPA), .OPB(OPB), .OPC(OPC),
        .BUSY(BUSY), .DONE(DONE), .OVF(OVF),
        .RES_HI(RES_HI), .RES_LO(RES_LO),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CIN(ALU_CIN), .ALU_ADD(ALU_ADD),
        .ALU_BONLY(ALU_BONLY), .ALU_IRFC(ALU_IRFC), .ALU_IR(ALU_IR),
        .ALU_D(ALU_D), .ALU_C(ALU_C)
    );

    // Behavioural ALU: ADD gives carry out, SUB gives borrow (A < B).
    logic [16:0] alu_full;
    always_comb begin
        alu_full = 17'h0;
        if (ALU_IRFC && ALU_IR == 16'h000C)
            alu_full = {1'b0, ALU_A} + {1'b0, ALU_B};
        else if (ALU_IRFC && ALU_IR == 16'h000D)
            alu_full = {1'b0, ALU_A} - {1'b0, ALU_B};
        ALU_D = alu_full[15:0];
        ALU_C = alu_full[16];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, hi, lo}
    function automatic logic [32:0] model(input bit op, input logic [15:0] a, b, c);
        logic [31:0] dvd, q, r;
        if (!op)
            return {1'b0, 32'(a) * 32'(b)};
        if (a >= c)
            return {1'b1, 32'hFFFF_FFFF};
        dvd = {a, b};
        q = dvd / 32'(c);
        r = dvd % 32'(c);
        return {1'b0, r[15:0], q[15:0]};
    endfunction

    task automatic do_op(input string name, input bit op, input logic [15:0] a, b, c,
                         input bit mid, input bit chain);
        logic [32:0] e;
        int          cyc, done_cyc, exp_lat;
        bit          busy_ok;
        logic [15:0] exp_ir;
        e       = model(op, a, b, c);
        exp_lat = op ? (e[32] ? 2 : 18) : 17;
        exp_ir  = op ? 16'h000D : 16'h000C;
        busy_ok = 1'b1;
        if (!chain) @(negedge CLK);
        START = 1'b1; OP = op; OPA = a; OPB = b; OPC = c;
        @(negedge CLK);
        if (chain) begin
            check({name, ".start_at_done_ignored"}, 32'({BUSY, DONE}), 32'd0);
            check({name, ".res_held"}, {RES_HI, RES_LO}, {prev_hi, prev_lo});
            @(negedge CLK);
        end
        START = 1'b0;
        OPA = 16'($urandom); OPB = 16'($urandom); OPC = 16'($urandom);
        cyc = 1;
        done_cyc = 0;
        while (done_cyc == 0 && cyc <= 40) begin
            if (DONE === 1'b1) begin
                done_cyc = cyc;
            end else begin
                if (BUSY !== 1'b1 || RES_HI !== prev_hi || RES_LO !== prev_lo ||
                    ALU_IRFC !== 1'b1 || ALU_IR !== exp_ir)
                    busy_ok = 1'b0;
                if (mid && cyc == 5) begin
                    START = 1'b1; OP = ~op;
                    OPA = 16'($urandom); OPB = 16'($urandom); OPC = 16'($urandom);
                end else if (mid && cyc == 6) begin
                    START = 1'b0;
                end
                @(negedge CLK);
                cyc++;
            end
        end
        check({name, ".latency"}, 32'(done_cyc), 32'(exp_lat));
        check({name, ".busy_phase"}, 32'(busy_ok), 32'd1);
        check({name, ".busy_at_done"}, 32'(BUSY), 32'd0);
        check({name, ".alu_idle_at_done"}, {15'd0, ALU_IRFC, ALU_IR}, 32'd0);
        check({name, ".ovf"}, 32'(OVF), 32'(e[32]));
        check({name, ".res"}, {RES_HI, RES_LO}, e[31:0]);
        prev_hi = e[31:16];
        prev_lo = e[15:0];
    endtask

    initial begin
        bit          done_seen;
        bit          rop;
        logic [15:0] ra, rb, rc;
        RESET_N = 1'b0; START = 1'b0; OP = 1'b0;
        OPA = 16'h0; OPB = 16'h0; OPC = 16'h0;
        repeat (3) @(negedge CLK);
        check("reset.outputs", {13'd0, BUSY, DONE, OVF, RES_HI}, 32'd0);
        check("reset.res_lo", 32'(RES_LO), 32'd0);
        check("reset.alu", {12'd0, ALU_CIN, ALU_ADD, ALU_BONLY, ALU_IRFC, ALU_IR}, 32'd0);
        RESET_N = 1'b1;

        do_op("mul_ffff",  1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        do_op("mul_1234",  1'b0, 16'h1234, 16'h0010, 16'h0000, 1'b0, 1'b0);
        do_op("mul_zero",  1'b0, 16'h0000, 16'hABCD, 16'h0000, 1'b0, 1'b0);
        do_op("div_3",     1'b1, 16'h0001, 16'h0000, 16'h0003, 1'b0, 1'b0);
        do_op("div_8000",  1'b1, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b0);
        do_op("div_by0",   1'b1, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0);
        do_op("div_ovf",   1'b1, 16'h0003, 16'h0000, 16'h0003, 1'b0, 1'b0);
        do_op("mul_mid",   1'b0, 16'hBEEF, 16'h1357, 16'h0000, 1'b1, 1'b0);
        do_op("div_mid",   1'b1, 16'h0123, 16'h4567, 16'h89AB, 1'b1, 1'b0);
        do_op("div_chain", 1'b1, 16'h0042, 16'h9999, 16'h0100, 1'b0, 1'b1);
        do_op("ovf_chain", 1'b1, 16'hFFFF, 16'h0001, 16'h0002, 1'b0, 1'b1);
        do_op("mul_chain", 1'b0, 16'h8001, 16'hC003, 16'h0000, 1'b0, 1'b1);

        // Abort a multiply at RUN step 7 with reset.
        @(negedge CLK);
        START = 1'b1; OP = 1'b0; OPA = 16'h7777; OPB = 16'h9999;
        @(negedge CLK);
        START = 1'b0;
        repeat (7) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("abort.outputs", {13'd0, BUSY, DONE, OVF, RES_HI}, 32'd0);
        check("abort.res_lo", 32'(RES_LO), 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE !== 1'b0) done_seen = 1'b1;
        end
        RESET_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE !== 1'b0) done_seen = 1'b1;
        end
        check("abort.no_done", 32'(done_seen), 32'd0);
        prev_hi = 16'h0;
        prev_lo = 16'h0;
        do_op("after_reset", 1'b0, 16'h7777, 16'h9999, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            rop = 1'($urandom);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 16'($urandom);
            if (rop && (i % 4 != 0)) begin
                if (rc == 16'h0) rc = 16'h1;
                ra = ra % rc;
            end
            do_op("rnd", rop, ra, rb, rc, 1'($urandom % 4 == 0) && !(rop && ra >= rc), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
